elevator_scan_ctrl: RTL and testbench

Parametrised N-floor elevator controller using SCAN (direction-preference) scheduling. It replaces the fixed 4-floor, 1-cycle-per-floor controller with three additions: configurable floor count, multi-cycle floor-to-floor travel, and door timing with hold/reopen. It also adds an emergency stop that can resume an interrupted floor transit. It drives the motor/door LEDs at board top level and exposes position and pending requests for display.

---
 rtl/elevator_scan_ctrl.sv | 116 +++++++++++
 tb/tb_elevator_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor SCAN elevator controller with multi-cycle travel, timed door and emergency halt/resume.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_W     = $clog2(NUM_FLOORS),
    parameter int TRAVEL_TIME = 4,
    parameter int DOOR_TIME   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  door_hold,
    input  logic                  estop,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  move_up,
    output logic                  move_down,
    output logic                  door_open,
    output logic                  arrived
);
    localparam int TW = TRAVEL_TIME > 1 ? $clog2(TRAVEL_TIME) : 1;
    localparam int DW = $clog2(DOOR_TIME);

    typedef enum logic [2:0] {IDLE, MOVE, ARRIVE, DOOR, HALT} state_t;

    state_t                state, state_nx;
    logic [TW-1:0]         travel_cnt, travel_nx;
    logic [DW-1:0]         door_cnt, door_nx;
    logic [FLOOR_W-1:0]    floor_nx;
    logic                  dir_nx, halted_in_move, halted_nx;
    logic                  above, below;
    logic [NUM_FLOORS-1:0] clr;

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(current_floor)) above = above | pending[i];
            if (i < int'(current_floor)) below = below | pending[i];
        end
    end

    always_comb begin
        state_nx  = state;
        travel_nx = travel_cnt;
        door_nx   = door_cnt;
        floor_nx  = current_floor;
        dir_nx    = dir_up;
        halted_nx = halted_in_move;
        if (estop) begin
            state_nx = HALT;
            if (state != HALT) halted_nx = (state == MOVE);
        end else begin
            case (state)
                IDLE, ARRIVE: begin
                    if (pending[current_floor]) begin
                        state_nx = DOOR;
                        door_nx  = '0;
                    end else if (above || below) begin
                        // keep heading while work lies ahead, otherwise turn around
                        state_nx = MOVE;
                        dir_nx   = dir_up ? above : ~below;
                    end else if (state == IDLE && door_hold) begin
                        state_nx = DOOR;
                        door_nx  = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                MOVE: begin
                    if (travel_cnt == TW'(TRAVEL_TIME - 1)) begin
                        floor_nx  = dir_up ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);
                        travel_nx = '0;
                        state_nx  = ARRIVE;
                    end else begin
                        travel_nx = travel_cnt + TW'(1);
                    end
                end
                DOOR: begin
                    if (door_hold || req[current_floor]) door_nx = '0;
                    else if (door_cnt == DW'(DOOR_TIME - 1)) state_nx = IDLE;
                    else door_nx = door_cnt + DW'(1);
                end
                HALT:    state_nx = halted_in_move ? MOVE : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign clr = (state_nx == DOOR) ? NUM_FLOORS'(1) << current_floor : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            current_floor  <= '0;
            dir_up         <= 1'b1;
            pending        <= '0;
            travel_cnt     <= '0;
            door_cnt       <= '0;
            halted_in_move <= 1'b0;
        end else begin
            state          <= state_nx;
            current_floor  <= floor_nx;
            dir_up         <= dir_nx;
            pending        <= (pending | req) & ~clr;
            travel_cnt     <= travel_nx;
            door_cnt       <= door_nx;
            halted_in_move <= halted_nx;
        end
    end

    assign move_up   = (state == MOVE) && dir_up;
    assign move_down = (state == MOVE) && !dir_up;
    assign door_open = (state == DOOR);
    assign arrived   = (state == ARRIVE);
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl: random and directed stimulus against a timer-based car model; a monitor scores every output change.
module tb_elevator_scan_ctrl;
    localparam int N  = 8;
    localparam int FW = 3;
    localparam int TT = 4;
    localparam int DT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic          door_hold = 1'b0;
    logic          estop = 1'b0;
    logic [FW-1:0] current_floor;
    logic          dir_up, move_up, move_down, door_open, arrived;
    logic [N-1:0]  pending;
    logic [15:0]   out_vec;

    elevator_scan_ctrl #(.NUM_FLOORS(N), .FLOOR_W(FW), .TRAVEL_TIME(TT), .DOOR_TIME(DT)) dut (
        .clk(clk), .rst(rst), .req(req), .door_hold(door_hold), .estop(estop),
        .current_floor(current_floor), .dir_up(dir_up), .pending(pending),
        .move_up(move_up), .move_down(move_down), .door_open(door_open), .arrived(arrived)
    );

    assign out_vec = {current_floor, dir_up, pending, move_up, move_down, door_open, arrived};

    always #5 clk = ~clk;

    typedef struct {int cyc; logic [15:0] vec;} ev_t;
    ev_t         sb[$];
    ev_t         ev;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [15:0] prev_vec = 16'h1000;
    logic [15:0] last_exp = 16'h1000;

    always @(posedge clk) cyc <= cyc + 1;

    // car model: position advances by countdown timers, door open time is a countdown
    int       m_floor, m_ticks, m_door;
    bit       m_dir, m_moving, m_arrive, m_halt, m_saved;
    bit [N-1:0] m_pend;

    task automatic model_reset();
        m_floor = 0; m_dir = 1'b1; m_pend = '0; m_moving = 0; m_arrive = 0;
        m_halt = 0; m_saved = 0; m_ticks = 0; m_door = 0;
    endtask

    function automatic bit pend_beyond(input bit upward);
        for (int i = 0; i < N; i++)
            if (m_pend[i] && (upward ? i > m_floor : i < m_floor)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit r, input bit [N-1:0] q, input bit h, input bit e);
        bit up, dn;
        if (r) begin
            model_reset();
            return;
        end
        up = pend_beyond(1'b1);
        dn = pend_beyond(1'b0);
        if (e) begin
            if (!m_halt) m_saved = m_moving;
            m_halt = 1; m_moving = 0; m_arrive = 0; m_door = 0;
        end else if (m_halt) begin
            m_halt = 0;
            m_moving = m_saved;
        end else if (m_moving) begin
            m_ticks--;
            if (m_ticks == 0) begin
                m_floor += m_dir ? 1 : -1;
                m_moving = 0;
                m_arrive = 1;
            end
        end else if (m_door > 0) begin
            if (h || q[m_floor]) m_door = DT;
            else m_door--;
        end else begin
            if (m_pend[m_floor]) m_door = DT;
            else if (up || dn) begin
                if (!(m_dir ? up : dn)) m_dir = !m_dir;
                m_moving = 1;
                m_ticks = TT;
            end else if (!m_arrive && h) m_door = DT;
            m_arrive = 0;
        end
        m_pend = m_pend | q;
        if (m_door > 0) m_pend[m_floor] = 1'b0;
    endtask

    function automatic logic [15:0] exp_vec();
        return {3'(m_floor), m_dir, m_pend, m_moving & m_dir, m_moving & !m_dir, m_door > 0, m_arrive};
    endfunction

    task automatic drive(input bit r, input bit [N-1:0] q, input bit h, input bit e);
        logic [15:0] v;
        ev_t p;
        rst = r; req = q; door_hold = h; estop = e;
        model_step(r, q, h, e);
        v = exp_vec();
        if (v != last_exp) begin
            p.cyc = cyc + 1;
            p.vec = v;
            sb.push_back(p);
            last_exp = v;
        end
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && out_vec !== prev_vec) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%h want=none", cyc, out_vec);
            end else begin
                ev = sb.pop_front();
                if (ev.cyc != cyc || ev.vec !== out_vec) begin
                    failures++;
                    $display("FAIL output_event cyc=%0d got=%h want=%h at cyc %0d", cyc, out_vec, ev.vec, ev.cyc);
                end
            end
            prev_vec = out_vec;
            if (failures >= 30) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    int mu_cnt, arr_cnt, door_cnt_obs, first_door, reached, halt_bad, hold_left, stop_left;
    bit r_b;
    bit [N-1:0] q_b;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_floor", current_floor, 0);
        chk("rst_dir_up", dir_up, 1);
        chk("rst_pending", pending, 0);
        chk("rst_motor_door", {move_up, move_down, door_open, arrived}, 0);
        mon_en = 1'b1;

        mu_cnt = 0; arr_cnt = 0; door_cnt_obs = 0;
        drive(0, 8'h20, 0, 0);
        for (int n = 0; n < 60; n++) begin
            mu_cnt += move_up; arr_cnt += arrived; door_cnt_obs += door_open;
            drive(0, 0, 0, 0);
        end
        chk("run5_move_up_cycles", mu_cnt, 20);
        chk("run5_arrivals", arr_cnt, 5);
        chk("run5_door_cycles", door_cnt_obs, DT);
        chk("run5_floor", current_floor, 5);
        chk("run5_pending", pending, 0);

        drive(1, 0, 0, 0);
        drive(0, 8'h81, 0, 0);
        first_door = -1; reached = 0;
        for (int n = 0; n < 200 && !reached; n++) begin
            if (door_open && first_door < 0) first_door = current_floor;
            if (m_floor == 7 && m_door > 0) reached = 1;
            else drive(0, 0, 0, 0);
        end
        chk("first_door_floor", first_door, 0);
        chk("reach_top_door", reached, 1);
        drive(0, 8'h04, 0, 0);
        chk("top_door_pending2", {door_open, pending}, {1'b1, 8'h04});
        drive(1, 0, 0, 0);
        chk("rst_in_door_outputs", {move_up, move_down, door_open, arrived}, 0);
        chk("rst_in_door_floor_pend", {current_floor, pending}, 0);

        drive(0, 8'h02, 0, 0);
        for (int n = 0; n < 20 && !(m_moving && m_ticks == TT - 2); n++) drive(0, 0, 0, 0);
        chk("reach_mid_transit", m_moving && m_ticks == TT - 2, 1);
        halt_bad = 0;
        for (int n = 0; n < 10; n++) begin
            drive(0, 0, 0, 1);
            if (move_up || move_down || current_floor != 0) halt_bad++;
        end
        chk("halt_frozen", halt_bad, 0);
        for (int n = 0; n < 30; n++) drive(0, 0, 0, 0);
        chk("resumed_floor", current_floor, 1);

        door_cnt_obs = 0;
        for (int n = 0; n < 20; n++) begin
            drive(0, 0, 1, 0);
            door_cnt_obs += door_open;
        end
        chk("hold_door_cycles", door_cnt_obs, 20);
        door_cnt_obs = 0;
        for (int n = 0; n < 20; n++) begin
            drive(0, 0, 0, 0);
            door_cnt_obs += door_open;
        end
        chk("post_hold_door_cycles", door_cnt_obs, DT - 1);

        hold_left = 0; stop_left = 0;
        for (int n = 0; n < 4000; n++) begin
            r_b = ($urandom_range(0, 1499) == 0);
            q_b = ($urandom_range(0, 7) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            if (hold_left == 0 && $urandom_range(0, 59) == 0) hold_left = $urandom_range(1, 15);
            if (stop_left == 0 && $urandom_range(0, 199) == 0) stop_left = $urandom_range(1, 12);
            drive(r_b, q_b, hold_left > 0, stop_left > 0);
            if (hold_left > 0) hold_left--;
            if (stop_left > 0) stop_left--;
        end
        for (int n = 0; n < 100; n++) drive(0, 0, 0, 0);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_outputs", out_vec, last_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
